// File: rtl/simon_pkg.sv
// Shared definitions for the Simon 64/128 controller: word and key sizes,
// the z3 round-constant sequence, the key-schedule constant, the controller
// state type and 32-bit rotate helpers.
package simon_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned KEY_WORDS = 4;

  // z3 sequence; character i counted from the left is bit [61-i]
  localparam logic [61:0] Z3 =
    62'b11011011101011000110010111100000010010001010011100110100001111;

  // ~k ^ 3 folded into a single XOR constant
  localparam logic [WORD_W-1:0] KS_C = 32'hFFFF_FFFC;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic word_t rol(input word_t w, input int unsigned n);
    return (w << n) | (w >> (WORD_W - n));
  endfunction

  function automatic word_t ror(input word_t w, input int unsigned n);
    return (w >> n) | (w << (WORD_W - n));
  endfunction

  // Round constant for round i, taking characters left to right
  function automatic logic z_bit(input logic [61:0] z, input logic [5:0] i);
    return z[6'd61 - i];
  endfunction

endpackage

// File: rtl/simon_key_sched.sv
// On-the-fly Simon 64/128 key schedule: a four-word key shift register that
// produces one new key word per round.
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   load       capture key into k0..k3 (k0 = key[31:0])
//   step       advance the schedule by one round
//   round      round index selecting the z3 constant bit
//   key        128-bit key {k3,k2,k1,k0}
//   k0         round key for the current round
module simon_key_sched
  import simon_pkg::*;
#(
  parameter logic [61:0] ZSEQ = Z3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          load,
  input  logic                          step,
  input  logic [5:0]                    round,
  input  logic [KEY_WORDS*WORD_W-1:0]   key,
  output word_t                         k0
);

  word_t k0_q, k1_q, k2_q, k3_q;
  word_t t, t2, knew;

  always_comb begin
    t    = ror(k3_q, 3) ^ k1_q;
    t2   = t ^ ror(t, 1);
    knew = k0_q ^ KS_C ^ t2 ^ {31'b0, z_bit(ZSEQ, round)};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      k0_q <= '0;
      k1_q <= '0;
      k2_q <= '0;
      k3_q <= '0;
    end else if (load) begin
      {k3_q, k2_q, k1_q, k0_q} <= key;
    end else if (step) begin
      k0_q <= k1_q;
      k1_q <= k2_q;
      k2_q <= k3_q;
      k3_q <= knew;
    end
  end

  assign k0 = k0_q;

endmodule

// File: rtl/simon64_128_ctrl.sv
// Iterative Simon 64/128 encryption controller: accepts a plaintext/key
// request, runs one round per clock for ROUNDS rounds, then holds the
// ciphertext until the consumer takes it.
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   in_valid   request valid (pt/key sampled only on accept)
//   in_ready   controller idle and able to accept
//   key        128-bit key {k3,k2,k1,k0}
//   pt         plaintext {x,y}
//   out_valid  ct holds a finished ciphertext
//   out_ready  consumer accepts ct
//   ct         ciphertext {x,y}
//   busy       request in progress (RUN or DONE)
module simon64_128_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned ROUNDS = 44,
  parameter logic [61:0] ZSEQ   = Z3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [63:0]  pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  ct,
  output logic         busy
);

  state_t     state, state_nxt;
  logic [5:0] rnd;
  word_t      x, y, k0, x_nxt;
  logic       accept, run, last_round;

  assign in_ready   = (state == IDLE) && rstn;
  assign accept     = in_valid && in_ready;
  assign run        = (state == RUN);
  assign last_round = (rnd == 6'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = RUN;
      RUN:     if (last_round) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Simon round: f(x) = (x<<<1 & x<<<8) ^ x<<<2
  always_comb begin
    x_nxt = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ y ^ k0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      x   <= '0;
      y   <= '0;
      rnd <= '0;
    end else if (accept) begin
      x   <= pt[63:32];
      y   <= pt[31:0];
      rnd <= '0;
    end else if (run) begin
      x   <= x_nxt;
      y   <= x;
      rnd <= rnd + 6'd1;
    end
  end

  simon_key_sched #(
    .ZSEQ(ZSEQ)
  ) u_key_sched (
    .clk   (clk),
    .rstn  (rstn),
    .load  (accept),
    .step  (run),
    .round (rnd),
    .key   (key),
    .k0    (k0)
  );

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign ct        = {x, y};

endmodule

// File: tb/tb_simon64_128_ctrl.sv
module tb_simon64_128_ctrl;

  localparam logic [127:0] KEY_STD = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT_STD  = 64'h656b696c_20646e75;
  localparam logic [63:0]  CT_STD  = 64'h44c8fc20_b9dfa07a;
  localparam logic [63:0]  PT_B    = 64'h01234567_89abcdef;
  localparam logic [127:0] KEY_R1  = 128'h00000000_00000000_00000000_000000ff;
  localparam logic [63:0]  PT_R1   = 64'h00000000_12345678;
  localparam logic [63:0]  CT_R1   = 64'h12345687_00000000;

  logic         clk;
  logic         rstn;
  logic         out_ready;
  logic [127:0] key;
  logic [63:0]  pt;
  logic         iv  [2];
  logic         ir  [2];
  logic         ov  [2];
  logic         bz  [2];
  logic [63:0]  cto [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // transaction-level model state per instance
  int          rnds    [2] = '{44, 1};
  bit          m_busy  [2] = '{0, 0};
  int          m_left  [2] = '{0, 0};
  logic [63:0] m_ct    [2];
  int          acc_cnt [2] = '{0, 0};
  int          acc_cyc [2] = '{0, 0};
  int          rise_cnt[2] = '{0, 0};
  int          rise_cyc[2] = '{0, 0};
  logic [63:0] ct_cap  [2];
  bit          ov_prev [2] = '{0, 0};

  simon64_128_ctrl u_dut44 (
    .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]),
    .key(key), .pt(pt), .out_valid(ov[0]), .out_ready(out_ready),
    .ct(cto[0]), .busy(bz[0])
  );

  simon64_128_ctrl #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]),
    .key(key), .pt(pt), .out_valid(ov[1]), .out_ready(out_ready),
    .ct(cto[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  // Reference encryption: full key expansion up front, then r rounds
  function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [127:0] k, input int r);
    logic [61:0] z;
    logic [31:0] kw [66];
    logic [31:0] x, y, tmp;
    z = 62'b11011011101011000110010111100000010010001010011100110100001111;
    for (int i = 0; i < 4; i++) kw[i] = k[32*i +: 32];
    for (int i = 0; i + 4 < 66 && i < r; i++) begin
      tmp = rl(kw[i+3], 29) ^ kw[i+1];
      tmp = tmp ^ rl(tmp, 31);
      kw[i+4] = ~kw[i] ^ 32'd3 ^ tmp ^ {31'b0, z[61-i]};
    end
    x = p[63:32];
    y = p[31:0];
    for (int i = 0; i < r; i++) begin
      tmp = x;
      x   = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ kw[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // Model update at each edge, compare 1 time unit later
  always begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_busy[i] = 0;
        m_left[i] = 0;
      end else if (!m_busy[i]) begin
        if (iv[i]) begin
          m_busy[i]  = 1;
          m_left[i]  = rnds[i];
          m_ct[i]    = ref_enc(pt, key, rnds[i]);
          acc_cnt[i] = acc_cnt[i] + 1;
          acc_cyc[i] = cyc;
        end
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
      end else if (out_ready) begin
        m_busy[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(!m_busy[i] && rstn));
      check($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(m_busy[i] && m_left[i] == 0));
      check($sformatf("busy[%0d]", i), 64'(bz[i]), 64'(m_busy[i]));
      if (m_busy[i] && m_left[i] == 0)
        check($sformatf("ct[%0d]", i), cto[i], m_ct[i]);
      if (ov[i] && !ov_prev[i]) begin
        rise_cnt[i] = rise_cnt[i] + 1;
        rise_cyc[i] = cyc;
        ct_cap[i]   = cto[i];
      end
      ov_prev[i] = ov[i];
    end
  end

  task automatic wait_acc(input int i, input int target, input string nm);
    int n = 0;
    while (acc_cnt[i] < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(acc_cnt[i] >= target), 64'd1);
  endtask

  task automatic wait_rise(input int i, input int target, input string nm);
    int n = 0;
    while (rise_cnt[i] < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(rise_cnt[i] >= target), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, r0, a0;
    rstn = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
    iv[0] = 1'b0; iv[1] = 1'b0;

    // model pinned against published / hand-computed values
    check("ref_std", ref_enc(PT_STD, KEY_STD, 44), CT_STD);
    check("ref_r1", ref_enc(PT_R1, KEY_R1, 1), CT_R1);

    repeat (3) @(negedge clk);
    check("rst_ct0", cto[0], 64'd0);
    check("rst_ct1", cto[1], 64'd0);
    check("rst_in_ready0", 64'(ir[0]), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #2;
    check("in_ready_after_release", 64'(ir[0]), 64'd1);

    // standard vector, latency, then backpressure in DONE
    @(negedge clk);
    pt = PT_STD; key = KEY_STD; iv[0] = 1'b1;
    wait_acc(0, 1, "accept_std");
    iv[0] = 1'b0;
    wait_rise(0, 1, "done_std");
    check("latency_std", 64'(rise_cyc[0] - acc_cyc[0]), 64'd44);
    check("ct_std", ct_cap[0], CT_STD);
    pt = ~PT_STD; key = ~KEY_STD; iv[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_no_accept", 64'(acc_cnt[0]), 64'd1);
    check("bp_ct_hold", cto[0], CT_STD);
    check("bp_ov_hold", 64'(ov[0]), 64'd1);
    iv[0] = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    check("in_ready_after_handshake", 64'(ir[0]), 64'd1);

    // back-to-back requests with in_valid held
    @(negedge clk);
    a0 = acc_cnt[0]; r0 = rise_cnt[0];
    pt = PT_STD; key = KEY_STD; iv[0] = 1'b1;
    wait_acc(0, a0 + 1, "accept_b2b_1");
    c1 = acc_cyc[0];
    pt = PT_B;
    wait_acc(0, a0 + 2, "accept_b2b_2");
    iv[0] = 1'b0;
    check("b2b_spacing", 64'(acc_cyc[0] - c1), 64'd46);
    wait_rise(0, r0 + 2, "done_b2b");
    check("ct_b2b_2", ct_cap[0], ref_enc(PT_B, KEY_STD, 44));
    repeat (2) @(negedge clk);

    // reset around round 20 aborts the block
    pt = PT_STD; key = KEY_STD; iv[0] = 1'b1;
    a0 = acc_cnt[0];
    wait_acc(0, a0 + 1, "accept_abort");
    iv[0] = 1'b0;
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    r0 = rise_cnt[0];
    repeat (60) @(negedge clk);
    check("abort_no_out_valid", 64'(rise_cnt[0]), 64'(r0));
    check("abort_idle", 64'(bz[0]), 64'd0);
    iv[0] = 1'b1;
    wait_acc(0, a0 + 2, "accept_after_abort");
    iv[0] = 1'b0;
    wait_rise(0, r0 + 1, "done_after_abort");
    check("ct_after_abort", ct_cap[0], CT_STD);
    repeat (2) @(negedge clk);

    // ROUNDS=1 instance
    pt = PT_R1; key = KEY_R1; iv[1] = 1'b1;
    a0 = acc_cnt[1]; r0 = rise_cnt[1];
    wait_acc(1, a0 + 1, "accept_r1");
    iv[1] = 1'b0;
    wait_rise(1, r0 + 1, "done_r1");
    check("latency_r1", 64'(rise_cyc[1] - acc_cyc[1]), 64'd1);
    check("ct_r1", ct_cap[1], CT_R1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
